// File: rtl/enum_pkg.sv
// Shared enumerated-digit link definitions: default framing and FSM encoding.
// Used by both the transmitter and enum_rx.
package enum_pkg;

  localparam int HOLD_DEF = 4;
  localparam int NDIG_DEF = 4;
  localparam int DW_DEF   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_window.sv
// Per-digit hold window: latches the first sample, counts hold cycles and
// flags any later sample in the window that disagrees with the first one.
module digit_window
  import enum_pkg::*;
#(
  parameter int HOLD = HOLD_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          run,
  input  logic          clear,
  input  logic [DW-1:0] digit,
  output logic [DW-1:0] cur,
  output logic          last_cycle,
  output logic          unstable
);

  localparam int SW = cnt_w(HOLD);

  logic [SW-1:0] sub_q, sub_d;
  logic [DW-1:0] cur_q, cur_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q <= '0;
      cur_q <= '0;
    end else begin
      sub_q <= sub_d;
      cur_q <= cur_d;
    end
  end

  always_comb begin
    sub_d      = sub_q;
    cur_d      = cur_q;
    last_cycle = 1'b0;
    unstable   = 1'b0;
    if (clear) begin
      sub_d = '0;
      cur_d = '0;
    end else if (load) begin
      cur_d = digit;
      sub_d = SW'(1);
    end else if (run) begin
      if (sub_q == '0) begin
        cur_d = digit;
        sub_d = SW'(1);
      end else begin
        unstable = (digit != cur_q);
        if (sub_q == SW'(HOLD - 1)) begin
          last_cycle = 1'b1;
          sub_d      = '0;
        end else begin
          sub_d = sub_q + SW'(1);
        end
      end
    end
  end

  assign cur = cur_q;

endmodule

// File: rtl/enum_rx.sv
// Enumerated-digit frame receiver: assembles NDIG held digits, MSB first,
// into one word and reports a one-cycle done with a stability error flag.
module enum_rx
  import enum_pkg::*;
#(
  parameter int HOLD = HOLD_DEF,
  parameter int NDIG = NDIG_DEF,
  parameter int DW   = DW_DEF,
  parameter int VW   = NDIG * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [DW-1:0] digit,
  output logic [VW-1:0] value,
  output logic          done,
  output logic          err,
  output logic          busy
);

  localparam int IW = cnt_w(NDIG);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] shift_q, shift_d;
  logic [VW-1:0] value_q, value_d;
  logic          errflag_q, errflag_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          win_load, win_run, win_clear;
  logic [DW-1:0] cur;
  logic          last_cycle, unstable;
  logic          err_now;

  assign win_load  = (state_q == IDLE) && en && start;
  assign win_run   = (state_q == RECV) && en;
  assign win_clear = (state_q == RECV) && !en;

  digit_window #(
    .HOLD(HOLD),
    .DW  (DW)
  ) u_win (
    .clk       (clk),
    .rst       (rst),
    .load      (win_load),
    .run       (win_run),
    .clear     (win_clear),
    .digit     (digit),
    .cur       (cur),
    .last_cycle(last_cycle),
    .unstable  (unstable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shift_q   <= '0;
      value_q   <= '0;
      errflag_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      value_q   <= value_d;
      errflag_q <= errflag_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    value_d   = value_q;
    errflag_d = errflag_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_now   = errflag_q | unstable;
    unique case (state_q)
      IDLE: begin
        if (en && start) begin
          state_d   = RECV;
          idx_d     = '0;
          shift_d   = '0;
          errflag_d = 1'b0;
        end
      end
      RECV: begin
        if (!en) begin
          // Abort: drop the partial frame, keep the last good value.
          state_d   = IDLE;
          idx_d     = '0;
          shift_d   = '0;
          errflag_d = 1'b0;
        end else begin
          errflag_d = err_now;
          if (last_cycle) begin
            shift_d = {shift_q[VW-DW-1:0], cur};
            if (idx_q == IW'(NDIG - 1)) begin
              value_d   = shift_d;
              err_d     = err_now;
              done_d    = 1'b1;
              state_d   = IDLE;
              idx_d     = '0;
              errflag_d = 1'b0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign value = value_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = (state_q == RECV);

endmodule
